sobel_filter: RTL and testbench
===============================

SOBEL_FILTER -- requirements
Module: sobel_filter

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 720, pixels per row (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 540, rows per frame (>=3).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel bits.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_rd_en  output  1  pops input FIFO.
REQ-007 SHALL have port in_empty  input  1  input FIFO empty.
REQ-008 SHALL have port in_dout  input  DATA_WIDTH  input pixel, valid in the cycle in_rd_en is high.
REQ-009 SHALL have port out_wr_en  output  1  pushes output FIFO.
REQ-010 SHALL have port out_full  input  1  output FIFO full.
REQ-011 SHALL have port out_din  output  DATA_WIDTH  output pixel.
REQ-012 SHALL have port mode  input  2  0=(|Gx|+|Gy|)/2, 1=|Gx|, 2=|Gy|, 3=binary threshold of mode-0 value.
REQ-013 SHALL have port threshold  input  DATA_WIDTH  threshold for mode 3.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse on the last output pixel of a frame.

Function
REQ-015 SHALL consume IMG_WIDTH*IMG_HEIGHT raster-order pixels per frame and emit exactly IMG_WIDTH*IMG_HEIGHT raster-order pixels.
REQ-016 SHALL use states FILL, RUN, FLUSH; FILL->RUN after IMG_WIDTH+1 reads; RUN->FLUSH after the last input read of the frame; FLUSH->FILL after IMG_WIDTH+1 writes.
REQ-017 FILL: in_rd_en = !in_empty; out_wr_en = 0.
REQ-018 RUN: in_rd_en = out_wr_en = !in_empty && !out_full; one pixel in and one out per transfer cycle.
REQ-019 FLUSH: in_rd_en = 0; out_wr_en = !out_full; out_din = 0.
REQ-020 Output pixel k SHALL be written in the cycle input pixel k+IMG_WIDTH+1 is read (combinational from window registers, two line buffers, in_dout); no output register stage.
REQ-021 Border outputs (row 0, row IMG_HEIGHT-1, col 0, col IMG_WIDTH-1) SHALL be 0 in all modes.
REQ-022 For interior centre (r,c) with window p[i][j], i,j in {-1,0,1}: Gx = sum over i of w_i*(p[i][+1]-p[i][-1]), Gy = sum over j of w_j*(p[+1][j]-p[-1][j]), w = 1,2,1.
REQ-023 Gx, Gy SHALL be signed, DATA_WIDTH+4 bits; absolute values exact, no overflow.
REQ-024 Mode 0 result = (|Gx|+|Gy|)>>1; mode 1 = |Gx|; mode 2 = |Gy|; each saturated to 2^DATA_WIDTH-1.
REQ-025 Mode 3 result = all-ones if mode-0 result >= threshold, else 0.
REQ-026 mode and threshold SHALL be latched on the first read of each frame; changes mid-frame have no effect until the next frame.
REQ-027 Row/column counters SHALL wrap at IMG_WIDTH-1/IMG_HEIGHT-1; frame N+1 starts in FILL with no idle cycle required.
REQ-028 frame_done SHALL pulse with the final FLUSH write; never when out_full blocks that write.
REQ-029 No read SHALL occur while in_empty=1; no write while out_full=1; stalls SHALL not alter output values.

Reset
REQ-030 reset low SHALL immediately force state FILL, counters 0, in_rd_en=0, out_wr_en=0, frame_done=0, latched mode/threshold 0.
REQ-031 Line buffers and window registers need no reset; their stale contents SHALL never reach out_din.
REQ-032 Reset mid-frame SHALL discard the partial frame; the next input pixel is treated as pixel (0,0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=8)
REQ-033 Flat frame all 100, mode 0 -> 16 outputs, all 0, one frame_done.
REQ-034 Every row 0,0,255,255, mode 0 -> interior (1,1),(1,2),(2,1),(2,2) = 255 (Gx=1020 saturated), border 0; mode 2 -> all 0.
REQ-035 Rows 0,0,10,10 each row, mode 3, threshold 20 -> interior 255 (mode-0 value 20); threshold 21 -> interior 0.
REQ-036 Step frame with out_full held high 5 cycles mid-RUN and in_empty toggling -> no reads/writes while blocked; output identical to REQ-034.
REQ-037 Reset asserted after 7 reads, then a full step frame -> exactly 16 outputs equal to REQ-034.
REQ-038 Two back-to-back frames, mode changed from 0 to 1 during frame 1 -> frame 1 uses mode 0, frame 2 uses mode 1; two frame_done pulses.

Source files
------------

// File: rtl/sobel_filter_if.sv
// Pixel FIFO handshake and control bundle for the Sobel filter.
// master = the filter, slave = the FIFO/control environment.
interface sobel_filter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_rd_en;
    logic                  in_empty;
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  out_wr_en;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] out_din;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] threshold;
    logic                  frame_done;

    modport master (
        output in_rd_en, out_wr_en, out_din, frame_done,
        input  in_empty, in_dout, out_full, mode, threshold
    );

    modport slave (
        input  in_rd_en, out_wr_en, out_din, frame_done,
        output in_empty, in_dout, out_full, mode, threshold
    );
endinterface

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge filter: raster pixels in, same-size raster frame out.
// Output pixel k is produced combinationally while input pixel k+IMG_WIDTH+1 is read.
module sobel_filter #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    sobel_filter_if.master bus_io
);
    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam int unsigned GW = DATA_WIDTH + 4;
    localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] PixMax = '1;

    typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         in_col_q, in_col_d, out_col_q, out_col_d;
    logic [RW-1:0]         in_row_q, in_row_d, out_row_q, out_row_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] thr_q, thr_d;
    logic                  rd, wr, done;

    logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win_q [3][2];
    logic [DATA_WIDTH-1:0] p     [3][3];

    logic signed [GW-1:0]  gx, gy;
    logic [GW-1:0]         ax, ay, mag0;
    logic [DATA_WIDTH-1:0] result;
    logic                  border;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return signed'({4'b0000, v});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [GW-1:0] v);
        return (v > {4'b0000, PixMax}) ? PixMax : v[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        wr      = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StFill: begin
                rd = !bus_io.in_empty;
                if (rd && in_row_q == RW'(1) && in_col_q == '0) state_d = StRun;
            end
            StRun: begin
                rd = !bus_io.in_empty && !bus_io.out_full;
                wr = rd;
                if (rd && in_row_q == RowLast && in_col_q == ColLast) state_d = StFlush;
            end
            StFlush: begin
                wr = !bus_io.out_full;
                if (wr && out_row_q == RowLast && out_col_q == ColLast) begin
                    done    = 1'b1;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        if (rd) begin
            in_col_d = (in_col_q == ColLast) ? '0 : in_col_q + 1'b1;
            if (in_col_q == ColLast) in_row_d = (in_row_q == RowLast) ? '0 : in_row_q + 1'b1;
            // Configuration is sampled with the first pixel of each frame
            if (in_row_q == '0 && in_col_q == '0) begin
                mode_d = bus_io.mode;
                thr_d  = bus_io.threshold;
            end
        end
        if (wr) begin
            out_col_d = (out_col_q == ColLast) ? '0 : out_col_q + 1'b1;
            if (out_col_q == ColLast) out_row_d = (out_row_q == RowLast) ? '0 : out_row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFill;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            mode_q    <= '0;
            thr_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
        end
    end

    // lb1 holds the previous row, lb0 the row before it, both indexed by input column
    always_ff @(posedge clk) begin
        if (rd) begin
            lb1_q[in_col_q] <= bus_io.in_dout;
            lb0_q[in_col_q] <= lb1_q[in_col_q];
            win_q[0][0]     <= win_q[0][1];
            win_q[0][1]     <= lb0_q[in_col_q];
            win_q[1][0]     <= win_q[1][1];
            win_q[1][1]     <= lb1_q[in_col_q];
            win_q[2][0]     <= win_q[2][1];
            win_q[2][1]     <= bus_io.in_dout;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            p[i][0] = win_q[i][0];
            p[i][1] = win_q[i][1];
        end
        p[0][2] = lb0_q[in_col_q];
        p[1][2] = lb1_q[in_col_q];
        p[2][2] = bus_io.in_dout;

        gx = (ext(p[0][2]) - ext(p[0][0])) + (ext(p[1][2]) - ext(p[1][0]))
           + (ext(p[1][2]) - ext(p[1][0])) + (ext(p[2][2]) - ext(p[2][0]));
        gy = (ext(p[2][0]) - ext(p[0][0])) + (ext(p[2][1]) - ext(p[0][1]))
           + (ext(p[2][1]) - ext(p[0][1])) + (ext(p[2][2]) - ext(p[0][2]));
        ax   = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay   = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag0 = (ax + ay) >> 1;

        unique case (mode_q)
            2'd0:    result = sat(mag0);
            2'd1:    result = sat(ax);
            2'd2:    result = sat(ay);
            default: result = (sat(mag0) >= thr_q) ? PixMax : '0;
        endcase

        border = (out_row_q == '0) || (out_row_q == RowLast)
              || (out_col_q == '0) || (out_col_q == ColLast);
    end

    // Outputs are forced low while reset is held, independent of the clock
    assign bus_io.in_rd_en   = rd && reset;
    assign bus_io.out_wr_en  = wr && reset;
    assign bus_io.frame_done = done && reset;
    assign bus_io.out_din    = (state_q == StRun && !border) ? result : '0;
endmodule

// File: tb/tb_sobel_filter.sv
// Randomised self-checking bench for sobel_filter on a 4x4 frame with FIFO stall models.
module tb_sobel_filter;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int N  = W * H;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sobel_filter_if #(.DATA_WIDTH(DW)) bus ();

    sobel_filter #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    int        img [N];
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    int        fd_total, fd_bad, viol;
    bit        done;

    task automatic clear_all();
        in_q.delete();
        out_q.delete();
        exp_q.delete();
        fd_total = 0;
        fd_bad   = 0;
        viol     = 0;
    endtask

    // Image generators: kind 0 = flat 100, 1 = step 0,0,255,255, 2 = step 0,0,10,10, 3 = random
    task automatic make_frame(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       img[r*W+c] = 100;
                    1:       img[r*W+c] = (c >= 2) ? 255 : 0;
                    2:       img[r*W+c] = (c >= 2) ? 10 : 0;
                    default: img[r*W+c] = int'($urandom_range(255));
                endcase
                in_q.push_back(8'(img[r*W+c]));
            end
        end
    endtask

    function automatic int px(input int r, input int c);
        return img[r*W+c];
    endfunction

    // Expected output frame straight from the 3x3 Sobel definition on the 2-D image
    task automatic model_frame(input int m, input int t);
        int gx, gy, ax, ay, m0, v;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
                    v = 0;
                end else begin
                    gx = 0;
                    gy = 0;
                    for (int k = -1; k <= 1; k++) begin
                        gx += ((k == 0) ? 2 : 1) * (px(r+k, c+1) - px(r+k, c-1));
                        gy += ((k == 0) ? 2 : 1) * (px(r+1, c+k) - px(r-1, c+k));
                    end
                    ax = (gx < 0) ? -gx : gx;
                    ay = (gy < 0) ? -gy : gy;
                    m0 = (ax + ay) / 2;
                    if (m0 > 255) m0 = 255;
                    if (ax > 255) ax = 255;
                    if (ay > 255) ay = 255;
                    case (m)
                        0:       v = m0;
                        1:       v = ax;
                        2:       v = ay;
                        default: v = (m0 >= t) ? 255 : 0;
                    endcase
                end
                exp_q.push_back(8'(v));
            end
        end
    endtask

    task automatic drive(input int n_out, input int empty_pct, input int full_pct,
                         input int hold_at, input int chg_at, input logic [1:0] chg_mode);
        int reads = 0;
        int hold  = 0;
        bit held  = 0;
        done = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (chg_at > 0 && reads == chg_at) bus.mode = chg_mode;
            if (hold_at >= 0 && reads == hold_at && !held) begin
                hold = 5;
                held = 1;
            end
            bus.in_empty = (in_q.size() == 0) || (int'($urandom_range(99)) < empty_pct);
            bus.in_dout  = (in_q.size() != 0) ? in_q[0] : 8'($urandom);
            bus.out_full = (hold > 0) || (int'($urandom_range(99)) < full_pct);
            #1;
            if (bus.in_rd_en && bus.in_empty) viol++;
            if (bus.out_wr_en && bus.out_full) viol++;
            if (hold > 0 && (bus.in_rd_en || bus.out_wr_en)) viol++;
            if (bus.frame_done && !bus.out_wr_en) viol++;
            if (bus.in_rd_en && !bus.in_empty) begin
                void'(in_q.pop_front());
                reads++;
            end
            if (bus.out_wr_en && !bus.out_full) begin
                if (bus.frame_done) begin
                    fd_total++;
                    if ((out_q.size() % N) != N-1) fd_bad++;
                end
                out_q.push_back(bus.out_din);
            end
            if (hold > 0) hold--;
            if (out_q.size() >= n_out) begin
                done = 1;
                break;
            end
        end
        @(negedge clk);
        bus.in_empty = 1'b1;
        bus.out_full = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_empty  = 1'b0;
        bus.out_full  = 1'b0;
        bus.in_dout   = '0;
        bus.mode      = 2'd0;
        bus.threshold = '0;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (bus.in_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.in_rd_en);
        else n_pass++;
        n_total++;
        if (bus.out_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", bus.out_wr_en);
        else n_pass++;
        n_total++;
        if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.in_rd_en !== 1'b1 || bus.out_wr_en !== 1'b0)
            $display("FAIL fill_handshake: got rd=%b wr=%b want rd=1 wr=0",
                     bus.in_rd_en, bus.out_wr_en);
        else n_pass++;
        bus.in_empty = 1'b1;
        #1;
        n_total++;
        if (bus.in_rd_en !== 1'b0) $display("FAIL fill_empty_rd: got %b want 0", bus.in_rd_en);
        else n_pass++;
    endtask

    task automatic test_frames(input string name, input int kind, input int m, input int t,
                               input int empty_pct, input int full_pct, input int hold_at);
        clear_all();
        make_frame(kind);
        model_frame(m, t);
        bus.mode      = 2'(m);
        bus.threshold = 8'(t);
        drive(N, empty_pct, full_pct, hold_at, 0, 2'd0);
        n_total++;
        if (!done) $display("FAIL %s timeout: got %0d outputs want %0d", name, out_q.size(), N);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_total++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i])
                $display("FAIL %s pixel %0d: got %0d want %0d", name, i,
                         (i < out_q.size()) ? out_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (fd_total !== 1 || fd_bad !== 0)
            $display("FAIL %s frame_done: got %0d pulses (%0d misplaced) want 1",
                     name, fd_total, fd_bad);
        else n_pass++;
        n_total++;
        if (viol !== 0) $display("FAIL %s handshake: got %0d violations want 0", name, viol);
        else n_pass++;
    endtask

    task automatic test_known_values();
        test_frames("step_mode0", 1, 0, 0, 0, 0, -1);
        n_total++;
        if (out_q.size() > 5 && out_q[5] !== 8'd255)
            $display("FAIL step_centre: got %0d want 255", out_q[5]);
        else if (out_q.size() <= 5) $display("FAIL step_centre: got no output want 255");
        else n_pass++;
        test_frames("step_mode2", 1, 2, 0, 0, 0, -1);
        test_frames("thr20", 2, 3, 20, 0, 0, -1);
        n_total++;
        if (out_q.size() <= 6 || out_q[6] !== 8'd255)
            $display("FAIL thr20_centre: got %0d want 255", (out_q.size() > 6) ? out_q[6] : 8'hxx);
        else n_pass++;
        test_frames("thr21", 2, 3, 21, 0, 0, -1);
        n_total++;
        if (out_q.size() <= 6 || out_q[6] !== 8'd0)
            $display("FAIL thr21_centre: got %0d want 0", (out_q.size() > 6) ? out_q[6] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int got = 0;
        bus.mode     = 2'd0;
        bus.out_full = 1'b0;
        for (int cyc = 0; cyc < 50 && got < 7; cyc++) begin
            @(negedge clk);
            bus.in_empty = 1'b0;
            bus.in_dout  = 8'($urandom);
            #1;
            if (bus.in_rd_en) got++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (got !== 7 || bus.in_rd_en !== 1'b0 || bus.out_wr_en !== 1'b0)
            $display("FAIL midreset: got reads=%0d rd=%b wr=%b want reads=7 rd=0 wr=0",
                     got, bus.in_rd_en, bus.out_wr_en);
        else n_pass++;
        @(negedge clk);
        bus.in_empty = 1'b1;
        reset = 1'b1;
        test_frames("after_reset", 1, 0, 0, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        clear_all();
        make_frame(3);
        model_frame(0, 0);
        make_frame(3);
        model_frame(1, 0);
        bus.mode      = 2'd0;
        bus.threshold = 8'd0;
        drive(2*N, 10, 10, -1, 6, 2'd1);
        n_total++;
        if (!done) $display("FAIL b2b timeout: got %0d outputs want %0d", out_q.size(), 2*N);
        else n_pass++;
        for (int i = 0; i < 2*N; i++) begin
            n_total++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i])
                $display("FAIL b2b pixel %0d: got %0d want %0d", i,
                         (i < out_q.size()) ? out_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (fd_total !== 2 || fd_bad !== 0)
            $display("FAIL b2b frame_done: got %0d pulses (%0d misplaced) want 2", fd_total, fd_bad);
        else n_pass++;
        n_total++;
        if (viol !== 0) $display("FAIL b2b handshake: got %0d violations want 0", viol);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            test_frames("random", 3, int'($urandom_range(3)), int'($urandom_range(255)),
                        int'($urandom_range(40)), int'($urandom_range(40)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_frames("flat", 0, 0, 0, 0, 0, -1);
        test_known_values();
        test_frames("stall", 1, 0, 0, 40, 15, 8);
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
